// File: rtl/ram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_pkg                                                      |
// | Description : Shared constants and helpers for the byte-enable dual-port   |
// |               RAM: read-during-write mode encodings and lane count.        |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ram_pkg;

   // Read-during-write behaviour selectors for each port
   localparam int RDW_WRITE_FIRST = 0;
   localparam int RDW_READ_FIRST  = 1;
   localparam int RDW_NO_CHANGE   = 2;

   // Number of byte-enable lanes in a word
   function automatic int ram_num_bytes(input int data_width, input int byte_width);
      return data_width / byte_width;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ram_dp_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_dp_core                                                  |
// | Description : Inferred true dual-port storage array with per-lane writes   |
// |               and a registered, read-first raw output on each port.        |
// |               No reset: contents and read registers are never cleared.     |
// | Ports       : clk                    - system clock                        |
// |               en_a/en_b              - read-register update enable         |
// |               we_a/we_b    [NB]      - per-lane write strobes              |
// |               addr_a/addr_b          - word address                        |
// |               wdata_a/wdata_b        - write data                          |
// |               rd_a_q/rd_b_q          - word at address before this write   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ram_dp_core
   import ram_pkg::*;
#(
   parameter  int DATA_WIDTH    = 32,
   parameter  int ADDRESS_WIDTH = 8,
   parameter  int BYTE_WIDTH    = 8,
   localparam int NB            = ram_num_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
   input  logic                     clk,
   input  logic                     en_a,
   input  logic [NB-1:0]            we_a,
   input  logic [ADDRESS_WIDTH-1:0] addr_a,
   input  logic [DATA_WIDTH-1:0]    wdata_a,
   output logic [DATA_WIDTH-1:0]    rd_a_q,
   input  logic                     en_b,
   input  logic [NB-1:0]            we_b,
   input  logic [ADDRESS_WIDTH-1:0] addr_b,
   input  logic [DATA_WIDTH-1:0]    wdata_b,
   output logic [DATA_WIDTH-1:0]    rd_b_q
);

   localparam int DEPTH = 2 ** ADDRESS_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // The top level guarantees the two lane sets never overlap on one address,
   // so the order of the two writes below is irrelevant.
   always_ff @(posedge clk) begin
      for (int l = 0; l < NB; l++) begin
         if (we_a[l]) mem[addr_a][l*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_a[l*BYTE_WIDTH +: BYTE_WIDTH];
         if (we_b[l]) mem[addr_b][l*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_b[l*BYTE_WIDTH +: BYTE_WIDTH];
      end
      if (en_a) rd_a_q <= mem[addr_a];
      if (en_b) rd_b_q <= mem[addr_b];
   end

endmodule
`default_nettype wire

// File: rtl/ram_dual_port_be.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ram_dual_port_be                                             |
// | Description : True dual-port RAM with per-byte write enables, 1- or 2-cycle|
// |               read latency, per-port read-during-write mode, deterministic |
// |               write-write collision merge (port A wins) and valid outputs. |
// | Ports       : clk, rst_n (sync, active low)                                |
// |               enX/weX/beX/addrX/dataX - port X access (X = A, B)           |
// |               qX, qX_valid            - port X read data and valid pulse   |
// |               coll                    - overlapping write-write collision  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ram_dual_port_be
   import ram_pkg::*;
#(
   parameter  int DATA_WIDTH    = 32,
   parameter  int ADDRESS_WIDTH = 8,
   parameter  int BYTE_WIDTH    = 8,
   parameter  int READ_LATENCY  = 1,
   parameter  int RDW_MODE_A    = 0,
   parameter  int RDW_MODE_B    = 1,
   localparam int NB            = ram_num_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enA,
   input  logic                     weA,
   input  logic [NB-1:0]            beA,
   input  logic [ADDRESS_WIDTH-1:0] addrA,
   input  logic [DATA_WIDTH-1:0]    dataA,
   output logic [DATA_WIDTH-1:0]    qA,
   output logic                     qA_valid,
   input  logic                     enB,
   input  logic                     weB,
   input  logic [NB-1:0]            beB,
   input  logic [ADDRESS_WIDTH-1:0] addrB,
   input  logic [DATA_WIDTH-1:0]    dataB,
   output logic [DATA_WIDTH-1:0]    qB,
   output logic                     qB_valid,
   output logic                     coll
);

   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("ram_dual_port_be: READ_LATENCY must be 1 or 2");
   end
   if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
      $error("ram_dual_port_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end

   logic [1:0]                    acc;        // access accepted this edge
   logic [1:0][NB-1:0]            lanes_req;  // lanes each port asks to write
   logic [1:0][NB-1:0]            lanes_wr;   // lanes actually written (after A-wins merge)
   logic [1:0][ADDRESS_WIDTH-1:0] addr;
   logic [1:0][DATA_WIDTH-1:0]    wdata;
   logic [1:0][DATA_WIDTH-1:0]    rd_raw;
   logic [1:0][DATA_WIDTH-1:0]    q_out;
   logic [1:0]                    rd_en;
   logic [1:0]                    q_vld;
   logic                          same_addr;
   logic                          coll_d, coll_q;

   always_comb begin
      acc          = {enB & rst_n, enA & rst_n};
      addr         = {addrB, addrA};
      wdata        = {dataB, dataA};
      lanes_req[0] = (acc[0] & weA) ? beA : '0;
      lanes_req[1] = (acc[1] & weB) ? beB : '0;
      same_addr    = (addrA == addrB);
      lanes_wr[0]  = lanes_req[0];
      // Port B only lands on lanes port A leaves alone at the same address
      lanes_wr[1]  = same_addr ? (lanes_req[1] & ~lanes_req[0]) : lanes_req[1];
      coll_d       = same_addr & (|(lanes_req[0] & lanes_req[1]));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) coll_q <= 1'b0;
      else        coll_q <= coll_d;
   end

   ram_dp_core #(
      .DATA_WIDTH   (DATA_WIDTH),
      .ADDRESS_WIDTH(ADDRESS_WIDTH),
      .BYTE_WIDTH   (BYTE_WIDTH)
   ) u_core (
      .clk    (clk),
      .en_a   (rd_en[0]),
      .we_a   (lanes_wr[0]),
      .addr_a (addrA),
      .wdata_a(dataA),
      .rd_a_q (rd_raw[0]),
      .en_b   (rd_en[1]),
      .we_b   (lanes_wr[1]),
      .addr_b (addrB),
      .wdata_b(dataB),
      .rd_b_q (rd_raw[1])
   );

   for (genvar p = 0; p < 2; p++) begin : g_port
      localparam int MODE = (p == 0) ? RDW_MODE_A : RDW_MODE_B;

      logic                  is_write, upd, wf;
      logic [NB-1:0]         sel_a_d, sel_a_q, sel_b_d, sel_b_q;
      logic [DATA_WIDTH-1:0] dat_a_d, dat_a_q, dat_b_d, dat_b_q;
      logic [DATA_WIDTH-1:0] word;
      logic                  vld_d, vld_q;

      // upd: this access produces a result. A NO_CHANGE write produces none,
      // so the raw read register and lane selects hold and q keeps its value.
      // wf: the result is the finally stored word, rebuilt from the read-first
      // raw word by overlaying every lane either port wrote at this address.
      always_comb begin
         is_write = |lanes_req[p];
         upd      = acc[p] & ~(is_write & (MODE == RDW_NO_CHANGE));
         wf       = is_write & (MODE == RDW_WRITE_FIRST);
         sel_a_d  = sel_a_q;
         sel_b_d  = sel_b_q;
         dat_a_d  = dat_a_q;
         dat_b_d  = dat_b_q;
         if (upd) begin
            sel_a_d = (wf && addr[p] == addr[0]) ? lanes_wr[0] : '0;
            sel_b_d = (wf && addr[p] == addr[1]) ? lanes_wr[1] : '0;
            dat_a_d = wdata[0];
            dat_b_d = wdata[1];
         end
         vld_d = upd;
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            sel_a_q <= '0;
            sel_b_q <= '0;
            dat_a_q <= '0;
            dat_b_q <= '0;
            vld_q   <= 1'b0;
         end else begin
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            dat_a_q <= dat_a_d;
            dat_b_q <= dat_b_d;
            vld_q   <= vld_d;
         end
      end

      always_comb begin
         word = rd_raw[p];
         for (int l = 0; l < NB; l++) begin
            if (sel_a_q[l])      word[l*BYTE_WIDTH +: BYTE_WIDTH] = dat_a_q[l*BYTE_WIDTH +: BYTE_WIDTH];
            else if (sel_b_q[l]) word[l*BYTE_WIDTH +: BYTE_WIDTH] = dat_b_q[l*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end

      assign rd_en[p] = upd;

      if (READ_LATENCY == 2) begin : g_lat2
         logic [DATA_WIDTH-1:0] q2_d, q2_q;
         logic                  v2_d, v2_q;

         always_comb begin
            q2_d = vld_q ? word : q2_q;
            v2_d = vld_q;
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               q2_q <= '0;
               v2_q <= 1'b0;
            end else begin
               q2_q <= q2_d;
               v2_q <= v2_d;
            end
         end

         assign q_out[p] = q2_q;
         assign q_vld[p] = v2_q;
      end else begin : g_lat1
         // The raw read register has no reset, so q is forced to zero from a
         // reset until the first result arrives.
         logic clr_d, clr_q;

         always_comb clr_d = clr_q & ~upd;

         always_ff @(posedge clk) begin
            if (!rst_n) clr_q <= 1'b1;
            else        clr_q <= clr_d;
         end

         assign q_out[p] = clr_q ? '0 : word;
         assign q_vld[p] = vld_q;
      end
   end

   assign qA       = q_out[0];
   assign qA_valid = q_vld[0];
   assign qB       = q_out[1];
   assign qB_valid = q_vld[1];
   assign coll     = coll_q;

endmodule
`default_nettype wire
